// File: rtl/la_capture_pkg.sv
// Shared types for the logic-analyzer capture engine: the capture state
// machine encoding plus small decode helpers for the status outputs.
package la_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARMING = 3'd1,
    ST_ARMED  = 3'd2,
    ST_POST   = 3'd3,
    ST_DONE   = 3'd4
  } la_cap_state_t;

  // A capture is in progress from the accepted arm until the window is frozen.
  function automatic logic stateIsBusy(input la_cap_state_t s);
    return (s == ST_ARMING) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

  // The trigger word has been written once we are past ARMED.
  function automatic logic stateIsTriggered(input la_cap_state_t s);
    return (s == ST_POST) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/la_capture_ram.sv
// Simple dual-port capture buffer: one write port, one read port whose
// output register only updates on a read strobe, so data holds between reads.
module la_capture_ram #(
  parameter int DEPTH     = 1024,
  parameter int WIDTH     = 80,
  parameter int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]     wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]     rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; the array itself is never reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port, cleared by reset and held while no read is issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/la_capture_trigger.sv
// Logic-analyzer capture engine: registers the multi-slot sample word,
// evaluates a per-slot level/edge trigger, fills a circular buffer with a
// pre/post-trigger window and serves the frozen window through a read port.
module la_capture_trigger
  import la_capture_pkg::*;
#(
  parameter int NUM_LANES       = 16,
  parameter int SAMPLES_PER_CLK = 5,
  parameter int DEPTH           = 1024,
  parameter int ADDR_BITS       = $clog2(DEPTH)
) (
  input  logic                                   clk_250mhz,
  input  logic                                   rst,
  input  logic [NUM_LANES*SAMPLES_PER_CLK-1:0]   samples,
  input  logic                                   arm,
  input  logic                                   abort,
  input  logic [NUM_LANES-1:0]                   trig_mask,
  input  logic [NUM_LANES-1:0]                   trig_value,
  input  logic [NUM_LANES-1:0]                   trig_rise,
  input  logic [NUM_LANES-1:0]                   trig_fall,
  input  logic [ADDR_BITS-1:0]                   pre_depth,
  output logic                                   busy,
  output logic                                   triggered,
  output logic                                   done,
  output logic [$clog2(SAMPLES_PER_CLK)-1:0]     trig_slot,
  input  logic                                   rd_en,
  input  logic [ADDR_BITS-1:0]                   rd_addr,
  output logic [NUM_LANES*SAMPLES_PER_CLK-1:0]   rd_data
);

  localparam int WORD_BITS = NUM_LANES * SAMPLES_PER_CLK;
  localparam int SLOT_BITS = $clog2(SAMPLES_PER_CLK);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] MAX_ADDR = ADDR_BITS'(DEPTH - 1);

  la_cap_state_t state_q, state_d;

  logic [WORD_BITS-1:0]       stageWord_q;
  logic [NUM_LANES-1:0]       prevLast_q;
  logic [NUM_LANES-1:0]       lastSlot;

  logic [NUM_LANES-1:0]       cfgMask_q;
  logic [NUM_LANES-1:0]       cfgValue_q;
  logic [NUM_LANES-1:0]       cfgRise_q;
  logic [NUM_LANES-1:0]       cfgFall_q;
  logic [ADDR_BITS-1:0]       cfgPreDepth_q;

  logic [ADDR_BITS-1:0]       wrPtr_q, wrPtr_d;
  logic [ADDR_BITS-1:0]       cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]       trigPtr_q, trigPtr_d;
  logic [SLOT_BITS-1:0]       trigSlot_q, trigSlot_d;
  logic                       armSkip_q, armSkip_d;
  logic                       busy_q, triggered_q, done_q;

  logic [SAMPLES_PER_CLK-1:0] slotMatch;
  logic [SLOT_BITS-1:0]       firstSlot;
  logic                       anyMatch;
  logic                       armAccept;
  logic                       wrEn;
  logic [ADDR_BITS-1:0]       postLen;
  logic [ADDR_BITS-1:0]       readAddr;

  // Stage 1: register the incoming word and remember the newest slot of the
  // word currently in stage 2, so slot 0 can see its predecessor.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      stageWord_q <= '0;
      prevLast_q  <= '0;
    end else begin
      stageWord_q <= samples;
      prevLast_q  <= lastSlot;
    end
  end

  // Pick out the newest slot of every lane in the stage-2 word.
  always_comb begin
    lastSlot = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lastSlot[l] = stageWord_q[l*SAMPLES_PER_CLK + SAMPLES_PER_CLK - 1];
    end
  end

  for (genvar s = 0; s < SAMPLES_PER_CLK; s++) begin : gSlot
    logic [NUM_LANES-1:0] laneOk;
    for (genvar l = 0; l < NUM_LANES; l++) begin : gLane
      logic cur;
      logic prv;
      assign cur = stageWord_q[l*SAMPLES_PER_CLK + s];
      if (s == 0) begin : gFirst
        assign prv = prevLast_q[l];
      end else begin : gRest
        assign prv = stageWord_q[l*SAMPLES_PER_CLK + s - 1];
      end
      assign laneOk[l] = (!cfgMask_q[l] || (cur == cfgValue_q[l])) &&
                         (!cfgRise_q[l] || (!prv && cur)) &&
                         (!cfgFall_q[l] || (prv && !cur));
    end
    assign slotMatch[s] = &laneOk;
  end

  // Lowest matching slot wins, so scan from the top down.
  always_comb begin
    firstSlot = '0;
    for (int s = SAMPLES_PER_CLK - 1; s >= 0; s--) begin
      if (slotMatch[s]) begin
        firstSlot = SLOT_BITS'(s);
      end
    end
  end

  assign anyMatch  = |slotMatch;
  assign armAccept = arm && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  // pre_depth is ADDR_BITS wide, so it can never exceed DEPTH-1 and the
  // post-trigger length never underflows.
  assign postLen   = MAX_ADDR - cfgPreDepth_q;

  // Next-state logic: the cycle right after arm holds the word presented
  // alongside arm, so it is skipped and the window starts with the next one.
  always_comb begin
    state_d    = state_q;
    wrPtr_d    = wrPtr_q;
    cnt_d      = cnt_q;
    trigPtr_d  = trigPtr_q;
    trigSlot_d = trigSlot_q;
    armSkip_d  = 1'b0;
    wrEn       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (armAccept) begin
          state_d   = (pre_depth == '0) ? ST_ARMED : ST_ARMING;
          wrPtr_d   = '0;
          cnt_d     = '0;
          armSkip_d = 1'b1;
        end
      end
      ST_ARMING: begin
        if (!armSkip_q) begin
          wrEn    = 1'b1;
          wrPtr_d = wrPtr_q + ADDR_ONE;
          cnt_d   = cnt_q + ADDR_ONE;
          if (cnt_q + ADDR_ONE == cfgPreDepth_q) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end
        end
      end
      ST_ARMED: begin
        if (!armSkip_q) begin
          wrEn    = 1'b1;
          wrPtr_d = wrPtr_q + ADDR_ONE;
          if (anyMatch) begin
            trigPtr_d  = wrPtr_q;
            trigSlot_d = firstSlot;
            cnt_d      = '0;
            state_d    = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (postLen == '0) begin
          state_d = ST_DONE;
        end else begin
          wrEn    = 1'b1;
          wrPtr_d = wrPtr_q + ADDR_ONE;
          cnt_d   = cnt_q + ADDR_ONE;
          if (cnt_q + ADDR_ONE == postLen) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      wrEn      = 1'b0;
      armSkip_d = 1'b0;
    end
  end

  // Control registers, trigger configuration latched on arm, and the
  // registered status flags derived from the next state.
  always_ff @(posedge clk_250mhz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wrPtr_q       <= '0;
      cnt_q         <= '0;
      trigPtr_q     <= '0;
      trigSlot_q    <= '0;
      armSkip_q     <= 1'b0;
      cfgMask_q     <= '0;
      cfgValue_q    <= '0;
      cfgRise_q     <= '0;
      cfgFall_q     <= '0;
      cfgPreDepth_q <= '0;
      busy_q        <= 1'b0;
      triggered_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      cnt_q       <= cnt_d;
      trigPtr_q   <= trigPtr_d;
      trigSlot_q  <= trigSlot_d;
      armSkip_q   <= armSkip_d;
      busy_q      <= stateIsBusy(state_d);
      triggered_q <= stateIsTriggered(state_d);
      done_q      <= (state_d == ST_DONE);
      if (armAccept) begin
        cfgMask_q     <= trig_mask;
        cfgValue_q    <= trig_value;
        cfgRise_q     <= trig_rise;
        cfgFall_q     <= trig_fall;
        cfgPreDepth_q <= pre_depth;
      end
    end
  end

  // Window-relative read address; wraps naturally at ADDR_BITS.
  assign readAddr = trigPtr_q - cfgPreDepth_q + rd_addr;

  la_capture_ram #(
    .DEPTH     (DEPTH),
    .WIDTH     (WORD_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) uRam (
    .clk_i   (clk_250mhz),
    .rst_i   (rst),
    .we_i    (wrEn),
    .waddr_i (wrPtr_q),
    .wdata_i (stageWord_q),
    .re_i    (rd_en),
    .raddr_i (readAddr),
    .rdata_o (rd_data)
  );

  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;
  assign trig_slot = trigSlot_q;

endmodule

// File: tb/tb_la_capture_trigger.sv
// Self-checking bench for la_capture_trigger: drives known sample streams,
// keeps its own history of every presented word and checks status timing
// plus window readback against that history.
module tb_la_capture_trigger;

  localparam int LANES = 16;
  localparam int SPC   = 5;
  localparam int W     = LANES * SPC;
  localparam int HIST  = 1600;

  logic          clk_250mhz;
  logic          rst;
  logic [W-1:0]  samples;
  logic          arm;
  logic          abort;
  logic [15:0]   trig_mask;
  logic [15:0]   trig_value;
  logic [15:0]   trig_rise;
  logic [15:0]   trig_fall;
  logic [9:0]    pre_depth;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [2:0]    trig_slot;
  logic          rd_en;
  logic [9:0]    rd_addr;
  logic [W-1:0]  rd_data;

  typedef struct {
    int           rdAddr;
    logic [W-1:0] expData;
  } readVec_t;

  logic [W-1:0] hist [HIST];
  int           genMode;
  int           matchWords[$];
  int           matchSlot;
  int           edgeK;
  int           readAddrs[$];
  int           checkCount;
  int           failCount;

  la_capture_trigger #(
    .NUM_LANES       (LANES),
    .SAMPLES_PER_CLK (SPC),
    .DEPTH           (1024),
    .ADDR_BITS       (10)
  ) dut (
    .clk_250mhz (clk_250mhz),
    .rst        (rst),
    .samples    (samples),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_rise  (trig_rise),
    .trig_fall  (trig_fall),
    .pre_depth  (pre_depth),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_slot  (trig_slot),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk_250mhz = 1'b0;
  always #2 clk_250mhz = ~clk_250mhz;

  task automatic cycleStep();
    @(posedge clk_250mhz);
    @(negedge clk_250mhz);
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Background words keep lane 0 low; pattern words put 8'hA5 on lanes 7:0
  // in one slot; edge mode drives lane 0 high from word edgeK onwards.
  function automatic logic [W-1:0] genWord(input int k);
    logic [W-1:0] w;
    logic [7:0]   patt;
    patt      = 8'hA5;
    w[31:0]   = $urandom();
    w[63:32]  = $urandom();
    w[79:64]  = 16'($urandom());
    for (int s = 0; s < SPC; s++) w[s] = 1'b0;
    if (genMode == 0) begin
      foreach (matchWords[i]) begin
        if (matchWords[i] == k) begin
          for (int l = 0; l < 8; l++) w[l*SPC + matchSlot] = patt[l];
        end
      end
    end else if (k >= edgeK) begin
      for (int s = 0; s < SPC; s++) w[s] = 1'b1;
    end
    return w;
  endfunction

  // Drive one word of the stream and record it in the history.
  task automatic applyStimulus(input int k);
    samples = genWord(k);
    if (k >= 0) hist[k] = samples;
  endtask

  // Arm, stream words and check the status timing of one full capture.
  task automatic runCapture(input int pre, input logic [15:0] mask,
                            input logic [15:0] value, input logic [15:0] rise,
                            input logic [15:0] fall, input int trigWord,
                            input int expSlot);
    int postLen;
    int doneIter;
    postLen  = 1023 - pre;
    doneIter = trigWord + ((postLen > 0) ? postLen : 1) + 2;
    trig_mask  = mask;
    trig_value = value;
    trig_rise  = rise;
    trig_fall  = fall;
    pre_depth  = 10'(pre);
    arm        = 1'b1;
    applyStimulus(-1);
    cycleStep();
    arm        = 1'b0;
    trig_mask  = 16'hFFFF;
    trig_value = 16'($urandom());
    trig_rise  = 16'hFFFF;
    trig_fall  = 16'hFFFF;
    pre_depth  = 10'($urandom());
    for (int k = 0; k <= doneIter; k++) begin
      if (k == 0) checkOutput("busy_after_arm", W'(busy), W'(1));
      if (k == trigWord + 1) checkOutput("triggered_early", W'(triggered), W'(0));
      if (k == trigWord + 2) checkOutput("triggered_rise", W'(triggered), W'(1));
      if (k == doneIter - 1) checkOutput("done_early", W'(done), W'(0));
      if (k == doneIter) begin
        checkOutput("done_rise", W'(done), W'(1));
        checkOutput("busy_at_done", W'(busy), W'(0));
        checkOutput("trig_slot", W'(trig_slot), W'(expSlot));
      end
      applyStimulus(k);
      cycleStep();
    end
  endtask

  // Read back the window: expected words come from the history and are
  // queued when the read is issued, then popped when rd_data is valid.
  task automatic runReads(input int pre, input int trigWord);
    readVec_t vecs[$];
    readVec_t expQ[$];
    readVec_t cur;
    readVec_t last;
    foreach (readAddrs[i]) begin
      cur.rdAddr  = readAddrs[i];
      cur.expData = hist[trigWord - pre + readAddrs[i]];
      vecs.push_back(cur);
    end
    for (int i = 0; i < vecs.size(); i++) begin
      if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        checkOutput($sformatf("rd_data@%0d", cur.rdAddr), rd_data, cur.expData);
      end
      rd_en   = 1'b1;
      rd_addr = 10'(vecs[i].rdAddr);
      expQ.push_back(vecs[i]);
      cycleStep();
    end
    rd_en   = 1'b0;
    rd_addr = 10'($urandom());
    last    = expQ.pop_front();
    checkOutput($sformatf("rd_data@%0d", last.rdAddr), rd_data, last.expData);
    cycleStep();
    checkOutput("rd_data_hold", rd_data, last.expData);
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    rst        = 1'b1;
    arm        = 1'b0;
    abort      = 1'b0;
    trig_mask  = '0;
    trig_value = '0;
    trig_rise  = '0;
    trig_fall  = '0;
    pre_depth  = '0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    samples    = '0;
    genMode    = 0;
    matchSlot  = 0;
    edgeK      = 0;
    @(negedge clk_250mhz);
    cycleStep();
    cycleStep();
    checkOutput("reset_busy", W'(busy), W'(0));
    checkOutput("reset_triggered", W'(triggered), W'(0));
    checkOutput("reset_done", W'(done), W'(0));
    checkOutput("reset_trig_slot", W'(trig_slot), W'(0));
    checkOutput("reset_rd_data", rd_data, W'(0));
    rst = 1'b0;
    cycleStep();

    $display("[TB] pattern trigger, pre_depth=100");
    genMode = 0; matchWords = '{300}; matchSlot = 3;
    runCapture(100, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 300, 3);
    readAddrs = '{100, 0, 99, 101, 823, 824, 1023};
    runReads(100, 300);

    $display("[TB] pre-trigger suppression, pre_depth=50");
    matchWords = '{10, 49, 50}; matchSlot = 0;
    runCapture(50, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 50, 0);
    readAddrs = '{50, 49, 10, 0};
    runReads(50, 50);

    $display("[TB] immediate trigger, pre_depth=0");
    matchWords = '{0}; matchSlot = 4;
    runCapture(0, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 0, 4);
    readAddrs = '{0, 1, 1023};
    runReads(0, 0);

    $display("[TB] cross-word rising edge");
    genMode = 1; edgeK = 5;
    runCapture(0, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 5, 0);
    readAddrs = '{0, 1};
    runReads(0, 5);

    $display("[TB] clamp and wrap, pre_depth=1023");
    genMode = 0; matchWords = '{5, 1023}; matchSlot = 2;
    runCapture(1023, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 1023, 2);
    readAddrs = '{1023, 0, 1022, 5};
    runReads(1023, 1023);

    $display("[TB] ignored arm, abort in POST, arm+abort");
    matchWords = '{40}; matchSlot = 2;
    trig_mask = 16'h00FF; trig_value = 16'h00A5; trig_rise = '0; trig_fall = '0;
    pre_depth = 10'd20; arm = 1'b1;
    applyStimulus(-1);
    cycleStep();
    arm = 1'b0;
    for (int k = 0; k <= 57; k++) begin
      arm   = 1'b0;
      abort = 1'b0;
      if (k == 30) begin
        arm = 1'b1; trig_mask = '0; pre_depth = '0;
      end
      if (k == 35) begin
        checkOutput("ignored_arm_triggered", W'(triggered), W'(0));
        checkOutput("ignored_arm_busy", W'(busy), W'(1));
      end
      if (k == 42) begin
        checkOutput("armed_trigger", W'(triggered), W'(1));
        checkOutput("armed_trig_slot", W'(trig_slot), W'(2));
      end
      if (k == 50) abort = 1'b1;
      if (k == 51) begin
        checkOutput("abort_busy", W'(busy), W'(0));
        checkOutput("abort_triggered", W'(triggered), W'(0));
        checkOutput("abort_done", W'(done), W'(0));
      end
      if (k == 53) begin
        arm = 1'b1; abort = 1'b1;
      end
      if (k == 54 || k == 56) begin
        checkOutput("arm_abort_busy", W'(busy), W'(0));
        checkOutput("arm_abort_triggered", W'(triggered), W'(0));
      end
      applyStimulus(k);
      cycleStep();
    end
    arm = 1'b0; abort = 1'b0;

    $display("[TB] reset during POST then rearm");
    matchWords = '{20}; matchSlot = 1;
    trig_mask = 16'h00FF; trig_value = 16'h00A5; pre_depth = 10'd10; arm = 1'b1;
    applyStimulus(-1);
    cycleStep();
    arm = 1'b0;
    for (int k = 0; k <= 31; k++) begin
      rst = 1'b0;
      if (k == 22) checkOutput("pre_reset_triggered", W'(triggered), W'(1));
      if (k == 30) rst = 1'b1;
      if (k == 31) begin
        checkOutput("rst_busy", W'(busy), W'(0));
        checkOutput("rst_triggered", W'(triggered), W'(0));
        checkOutput("rst_done", W'(done), W'(0));
        checkOutput("rst_trig_slot", W'(trig_slot), W'(0));
        checkOutput("rst_rd_data", rd_data, W'(0));
      end
      applyStimulus(k);
      cycleStep();
    end
    rst = 1'b0;
    matchWords = '{15}; matchSlot = 1;
    runCapture(10, 16'h00FF, 16'h00A5, 16'h0000, 16'h0000, 15, 1);
    readAddrs = '{10, 0, 11};
    runReads(10, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/la_capture_trigger.md
# la_capture_trigger

Parametrised logic-analyzer capture engine for the logic pod datapaths. It takes the deserialised multi-slot sample words for N lanes and evaluates a per-slot pattern/edge trigger. It records a pre/post-trigger window into an on-chip circular buffer, then exposes the frozen window through a registered random-access read port. It sits in the 250 MHz sample domain downstream of the pod datapaths and replaces ad-hoc per-pod capture logic, with the lane count generalised across any number of pods.

## Interface
Parameters:
- NUM_LANES, 16, total lanes captured (8 per pod; 16 = two pods).
- SAMPLES_PER_CLK, 5, sample slots per lane per clock.
- DEPTH, 1024, buffer depth in words; power of two.
- ADDR_BITS, $clog2(DEPTH), buffer address width.

Ports:
- clk_250mhz  in  1  sample clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- samples  in  NUM_LANES*SAMPLES_PER_CLK  bit [lane*SAMPLES_PER_CLK + s]; slot s=0 is the oldest.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; returns the block to IDLE.
- trig_mask  in  NUM_LANES  level compare enable per lane.
- trig_value  in  NUM_LANES  required level where the mask bit is set.
- trig_rise  in  NUM_LANES  require a 0→1 transition on the lane.
- trig_fall  in  NUM_LANES  require a 1→0 transition on the lane.
- pre_depth  in  ADDR_BITS  number of pre-trigger words.
- busy  out  1  high in ARMING, ARMED or POST.
- triggered  out  1  high in POST or DONE.
- done  out  1  high in DONE.
- trig_slot  out  $clog2(SAMPLES_PER_CLK)  slot of the first match within the trigger word.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_BITS  word index relative to the window start.
- rd_data  out  NUM_LANES*SAMPLES_PER_CLK  read data.

## Operation
- States: IDLE, ARMING, ARMED, POST, DONE.
- Configuration inputs (trig_mask, trig_value, trig_rise, trig_fall, pre_depth) are latched on an accepted arm and ignored otherwise. A pre_depth of DEPTH-1 or more is clamped to DEPTH-1.
- arm is accepted in IDLE or DONE and moves the block to ARMING, with wr_ptr and the word counter cleared. arm is ignored in all other states.
- ARMING writes one word per clock. Once pre_depth words have been written, the block moves to ARMED. With pre_depth=0 it goes directly to ARMED. Trigger matches during ARMING are ignored.
- Slot s matches when every lane satisfies all of the following:
  - mask=0 or the level equals value;
  - rise=0 or prev=0 and cur=1;
  - fall=0 or prev=1 and cur=0.
- prev for slot s>0 is slot s-1 of the same word. prev for slot 0 is slot SAMPLES_PER_CLK-1 of the previous word, held in a register that updates every clock, including in IDLE.
- A word matches if any slot matches; trig_slot is the lowest matching slot.
- ARMED: the first matching word is written, trig_ptr is set to its address, and the block moves to POST.
- POST writes DEPTH-1-pre_depth further words, then enters DONE. Writes stop and the buffer is frozen.
- Readout address mapping: physical = (trig_ptr - pre_depth + rd_addr) mod DEPTH. rd_addr = pre_depth is therefore the trigger word. Address arithmetic wraps modulo DEPTH with no special casing.
- abort in any state goes to IDLE. It clears triggered, done and busy; buffer contents are untouched.
- If abort and arm occur in the same cycle, abort wins.
- rd_en is honoured in any state. Data read outside DONE is unspecified.

## Timing
- Reset: IDLE; busy=0, triggered=0, done=0, trig_slot=0, rd_data=0; the prev register is cleared. Reset mid-capture discards the capture.
- samples are registered once (stage 1). Match evaluation and the buffer write both occur in stage 2 on the registered word. A word presented at cycle N is written at cycle N+1.
- The status outputs are registered. triggered rises one cycle after the trigger word is written. done rises the cycle after the last POST write.
- arm at cycle N: the first word written is the word presented at cycle N+1.
- Read latency: rd_data is valid one clock after rd_en and holds until the next rd_en.

## Structure
- Package la_capture_pkg: the state enum la_cap_state_t.
- Sub-module la_capture_ram: simple dual-port inferred block RAM, DEPTH × (NUM_LANES*SAMPLES_PER_CLK). It has one write port and one read port with a registered output.
- Per-slot matching is a generate loop in the top module.

## Test plan
- Pattern trigger: mask=16'h00FF, value=16'h00A5, pre_depth=100; lanes 7:0 equal 8'hA5 only in slot 3 of word 300 after arm. Required: done=1, trig_slot=3, rd_addr=100 returns word 300, rd_addr=0 returns word 200.
- Cross-word edge: trig_rise bit 0 set; lane 0 is 1 only from slot 0 of word K, and 0 in slot 4 of word K-1. Required: trigger on word K, trig_slot=0.
- Pre-trigger suppression: a match occurs during ARMING with pre_depth=50. Required: no trigger until a match after 50 words. With pre_depth=0, an immediate match triggers on the first word.
- Clamp and wrap: pre_depth=1023, DEPTH=1024. Required: POST length 0; done one cycle after triggered; rd_addr=1023 returns the trigger word.
- Abort and busy-arm: arm pulses during ARMED are ignored; abort during POST gives busy=0, triggered=0 the next cycle. Simultaneous arm+abort stays in IDLE.
- Reset mid-POST: rst asserted for 1 cycle gives all outputs 0. A subsequent arm completes normally.
